// File: rtl/ip_sdram_arbiter_pkg.sv
// Shared types and default timing for the two-client SDRAM request arbiter.
// Holds the FSM state encoding, the client select and the latched request layout.
package ip_sdram_arbiter_pkg;

  localparam int ASSERT_CYCLES_DEF = 4;
  localparam int GAP_CYCLES_DEF    = 12;
  localparam int RD_TIMEOUT_DEF    = 64;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  typedef enum logic {
    CLI_CPU = 1'b0,
    CLI_DMA = 1'b1
  } cli_t;

  typedef struct packed {
    cli_t        cli;
    logic        wr;
    logic [22:0] address;
    logic [7:0]  wdata;
  } req_t;

endpackage

// File: rtl/ip_sdram_arbiter.sv
// Round-robin CPU/DMA arbiter that turns each granted byte request into one
// ip_sdram bus cycle (strobe window, optional read wait, recovery gap).
module ip_sdram_arbiter
  import ip_sdram_arbiter_pkg::*;
#(
  parameter int ASSERT_CYCLES = ASSERT_CYCLES_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int RD_TIMEOUT    = RD_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_en,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [22:0] dma_address,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_rdata_en,
  output logic        timeout_err,
  input  logic        sdram_busy,
  output logic        mreq_n,
  output logic        wr_n,
  output logic        rd_n,
  output logic        rfsh_n,
  output logic [22:0] address,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        rdata_en
);

  localparam logic [3:0] STRB_LAST = 4'(ASSERT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [6:0] TO_LAST   = 7'(RD_TIMEOUT - 1);

  state_t     state;
  req_t       req;
  req_t       sel;
  cli_t       last_cli;
  cli_t       grant_cli;
  logic       grant;
  logic       got_data;
  logic       capture;
  logic       timeout_hit;
  logic       ret_valid;
  logic [7:0] ret_data;
  logic [3:0] strb_cnt;
  logic [3:0] gap_cnt;
  logic [6:0] to_cnt;

  assign rfsh_n = 1'b1;

  // Grant selection: single requester wins outright, contention alternates.
  always_comb begin
    grant     = 1'b0;
    grant_cli = CLI_CPU;
    sel       = '0;
    if (!sdram_busy && cpu_req && dma_req) begin
      grant     = 1'b1;
      grant_cli = (last_cli == CLI_CPU) ? CLI_DMA : CLI_CPU;
    end else if (!sdram_busy && dma_req) begin
      grant     = 1'b1;
      grant_cli = CLI_DMA;
    end else if (!sdram_busy && cpu_req) begin
      grant     = 1'b1;
      grant_cli = CLI_CPU;
    end else begin
      grant     = 1'b0;
      grant_cli = CLI_CPU;
    end
    if (grant_cli == CLI_DMA) begin
      sel = '{cli: CLI_DMA, wr: dma_wr, address: dma_address, wdata: dma_wdata};
    end else begin
      sel = '{cli: CLI_CPU, wr: cpu_wr, address: cpu_address, wdata: cpu_wdata};
    end
  end

  // Read completion: first rdata_en of a read wins; otherwise the timeout returns 0xFF.
  always_comb begin
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (rdata_en && !req.wr && !got_data &&
        (state == ST_ASSERT || state == ST_WAIT_RD)) begin
      capture = 1'b1;
    end else begin
      capture = 1'b0;
    end
    if (state == ST_WAIT_RD && !capture && to_cnt == TO_LAST) begin
      timeout_hit = 1'b1;
    end else begin
      timeout_hit = 1'b0;
    end
    ret_valid = capture || timeout_hit;
    ret_data  = capture ? rdata : 8'hFF;
  end

  // Access sequencer with registered bus and client outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      req          <= '0;
      last_cli     <= CLI_DMA;
      got_data     <= 1'b0;
      strb_cnt     <= 4'd0;
      gap_cnt      <= 4'd0;
      to_cnt       <= 7'd0;
      mreq_n       <= 1'b1;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      address      <= 23'd0;
      wdata        <= 8'd0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_rdata_en <= 1'b0;
      dma_rdata_en <= 1'b0;
      cpu_rdata    <= 8'd0;
      dma_rdata    <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_rdata_en <= ret_valid && (req.cli == CLI_CPU);
      dma_rdata_en <= ret_valid && (req.cli == CLI_DMA);
      timeout_err  <= timeout_hit;
      if (ret_valid && req.cli == CLI_CPU) cpu_rdata <= ret_data;
      if (ret_valid && req.cli == CLI_DMA) dma_rdata <= ret_data;

      case (state)
        ST_INIT: begin
          if (!sdram_busy) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (grant) begin
            req      <= sel;
            last_cli <= grant_cli;
            cpu_ack  <= (grant_cli == CLI_CPU);
            dma_ack  <= (grant_cli == CLI_DMA);
            mreq_n   <= 1'b0;
            rd_n     <= sel.wr;
            wr_n     <= !sel.wr;
            address  <= sel.address;
            wdata    <= sel.wdata;
            strb_cnt <= 4'd0;
            got_data <= 1'b0;
            state    <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (capture) got_data <= 1'b1;
          if (strb_cnt == STRB_LAST) begin
            mreq_n  <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            address <= 23'd0;
            wdata   <= 8'd0;
            // A read answered inside the strobe window skips the wait state.
            if (req.wr || got_data || capture) begin
              gap_cnt <= 4'd0;
              state   <= ST_GAP;
            end else begin
              to_cnt <= 7'd0;
              state  <= ST_WAIT_RD;
            end
          end else begin
            address <= req.address;
            wdata   <= req.wdata;
            if (strb_cnt != 4'hF) strb_cnt <= strb_cnt + 4'd1;
          end
        end
        ST_WAIT_RD: begin
          if (ret_valid) begin
            gap_cnt <= 4'd0;
            state   <= ST_GAP;
          end else if (to_cnt != 7'h7F) begin
            to_cnt <= to_cnt + 7'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else if (gap_cnt != 4'hF) begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Randomized bench for ip_sdram_arbiter, checked every cycle against a
// timestamp-based transaction model of the arbitration and bus-cycle rules.
module tb_ip_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_wr, dma_req, dma_wr;
  logic [22:0] cpu_address, dma_address;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack, cpu_rdata_en, dma_rdata_en, timeout_err;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        sdram_busy;
  logic        mreq_n, wr_n, rd_n, rfsh_n;
  logic [22:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;

  always #5 clk = ~clk;

  ip_sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rdata_en(cpu_rdata_en),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rdata_en(dma_rdata_en),
    .timeout_err(timeout_err), .sdram_busy(sdram_busy),
    .mreq_n(mreq_n), .wr_n(wr_n), .rd_n(rd_n), .rfsh_n(rfsh_n),
    .address(address), .wdata(wdata), .rdata(rdata), .rdata_en(rdata_en)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Reference model: access timeline expressed as edge timestamps.
  bit          in_init, active, a_wr, a_dma, got, dma_last;
  int          g, idle_from;
  logic [22:0] a_addr;
  logic [7:0]  a_data;
  logic        e_cpu_ack, e_dma_ack, e_cpu_en, e_dma_en, e_terr;
  logic        e_mreq, e_rd, e_wr;
  logic [22:0] e_addr;
  logic [7:0]  e_wdata, e_cpu_rdata, e_dma_rdata;

  // Stimulus controls
  bit auto_clients = 0, hold_mode = 0, busy_rand = 0, no_resp = 0, spurious = 0, fixed_rdata = 0;
  bit rd_low_seen = 0;
  int resp_edge = -1;
  int resp_max = 10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic deliver(input logic [7:0] d);
    if (a_dma) begin e_dma_rdata = d; e_dma_en = 1'b1; end
    else       begin e_cpu_rdata = d; e_cpu_en = 1'b1; end
  endtask

  task automatic model_step();
    int  d;
    bit  cap;
    e_cpu_ack = 1'b0; e_dma_ack = 1'b0; e_cpu_en = 1'b0; e_dma_en = 1'b0; e_terr = 1'b0;
    e_mreq = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_addr = 23'd0; e_wdata = 8'd0;
    if (!reset_n) begin
      in_init = 1; active = 0; dma_last = 1;
      e_cpu_rdata = 8'd0; e_dma_rdata = 8'd0;
    end else if (in_init) begin
      if (!sdram_busy) begin in_init = 0; idle_from = k + 1; end
    end else if (!active) begin
      if (k >= idle_from && !sdram_busy && (cpu_req || dma_req)) begin
        a_dma    = dma_req && (!cpu_req || !dma_last);
        dma_last = a_dma;
        a_wr     = a_dma ? dma_wr : cpu_wr;
        a_addr   = a_dma ? dma_address : cpu_address;
        a_data   = a_dma ? dma_wdata : cpu_wdata;
        active = 1; got = 0; g = k;
        e_cpu_ack = !a_dma; e_dma_ack = a_dma;
        e_mreq = 1'b0; e_rd = a_wr; e_wr = !a_wr; e_addr = a_addr; e_wdata = a_data;
      end
    end else begin
      d   = k - g;
      cap = !a_wr && !got && rdata_en;
      if (cap) begin got = 1; deliver(rdata); end
      if (d < 4) begin
        e_mreq = 1'b0; e_rd = a_wr; e_wr = !a_wr; e_addr = a_addr; e_wdata = a_data;
      end else if (d == 4) begin
        if (a_wr || got) begin active = 0; idle_from = k + 13; end
      end else if (cap) begin
        active = 0; idle_from = k + 13;
      end else if (d == 68) begin
        deliver(8'hFF); e_terr = 1'b1; active = 0; idle_from = k + 13;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    model_step();
    #1;
    check("mreq_n", mreq_n, e_mreq);
    check("rd_n", rd_n, e_rd);
    check("wr_n", wr_n, e_wr);
    check("rfsh_n", rfsh_n, 1'b1);
    check("address", address, e_addr);
    check("wdata", wdata, e_wdata);
    check("cpu_ack", cpu_ack, e_cpu_ack);
    check("dma_ack", dma_ack, e_dma_ack);
    check("cpu_rdata_en", cpu_rdata_en, e_cpu_en);
    check("dma_rdata_en", dma_rdata_en, e_dma_en);
    check("cpu_rdata", cpu_rdata, e_cpu_rdata);
    check("dma_rdata", dma_rdata, e_dma_rdata);
    check("timeout_err", timeout_err, e_terr);
  endtask

  task automatic new_cpu();
    cpu_req = 1'b1; cpu_wr = 1'($urandom); cpu_address = 23'($urandom); cpu_wdata = 8'($urandom);
  endtask

  task automatic new_dma();
    dma_req = 1'b1; dma_wr = 1'($urandom); dma_address = 23'($urandom); dma_wdata = 8'($urandom);
  endtask

  // Client, SDRAM-responder and busy behaviour for the next edge.
  task automatic drive_inputs();
    if (cpu_ack) begin
      if (auto_clients && (hold_mode || $urandom_range(0, 1) == 1)) new_cpu(); else cpu_req = 1'b0;
    end else if (auto_clients) begin
      if (!cpu_req) begin if ($urandom_range(0, 3) == 0) new_cpu(); end
      else if (!hold_mode && $urandom_range(0, 63) == 0) cpu_req = 1'b0;
    end
    if (dma_ack) begin
      if (auto_clients && (hold_mode || $urandom_range(0, 1) == 1)) new_dma(); else dma_req = 1'b0;
    end else if (auto_clients) begin
      if (!dma_req) begin if ($urandom_range(0, 3) == 0) new_dma(); end
      else if (!hold_mode && $urandom_range(0, 63) == 0) dma_req = 1'b0;
    end
    if (rd_n == 1'b0 && !rd_low_seen) begin
      rd_low_seen = 1;
      resp_edge = no_resp ? -1 : k + $urandom_range(1, resp_max);
    end
    if (rd_n == 1'b1) rd_low_seen = 0;
    rdata_en = (resp_edge == k + 1) || (spurious && $urandom_range(0, 40) == 0);
    rdata    = fixed_rdata ? 8'h43 : 8'($urandom);
    if (busy_rand) sdram_busy = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; sdram_busy = 1'b0; rdata = 8'd0; rdata_en = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_address = 23'd0; cpu_wdata = 8'd0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_address = 23'd0; dma_wdata = 8'd0;
    repeat (3) step();

    // Busy after reset with a CPU write pending, then the write itself.
    reset_n = 1'b1; sdram_busy = 1'b1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_address = 23'h000003; cpu_wdata = 8'h45;
    repeat (200) begin step(); drive_inputs(); end
    sdram_busy = 1'b0;
    repeat (40) begin step(); drive_inputs(); end

    // Single CPU read answered with 0x43.
    fixed_rdata = 1; resp_max = 10;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_address = 23'h400002;
    repeat (60) begin step(); drive_inputs(); end
    fixed_rdata = 0;

    // Both clients held continuously, responses sometimes beyond the timeout.
    auto_clients = 1; hold_mode = 1; resp_max = 90;
    new_cpu(); new_dma();
    repeat (800) begin step(); drive_inputs(); end

    // Free-running random traffic with busy pulses and stray rdata_en.
    hold_mode = 0; busy_rand = 1; spurious = 1;
    repeat (3000) begin step(); drive_inputs(); end

    // Reset while a read waits for data that never comes.
    busy_rand = 0; sdram_busy = 1'b0; spurious = 0; no_resp = 1;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (active && !a_wr && (k - g) >= 8) begin found = 1; break; end
      drive_inputs();
    end
    check("reset_mid_read_reached", found, 1'b1);
    rdata_en = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1; sdram_busy = 1'b1;
    repeat (5) begin step(); drive_inputs(); end
    sdram_busy = 1'b0; no_resp = 0;
    repeat (200) begin step(); drive_inputs(); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
